// File: rtl/scoreboard_mc_pkg.sv
// Shared scoreboard constants: the constant-true predicate index, the predicate-field width
// and the default counter width. Decode uses the same constant for its predicate extension.
package scoreboard_mc_pkg;

   localparam int PRED_CONST_IDX = 3;
   localparam int PRED_IDX_W     = 2;   // predicate number is rd_num[1:0]
   localparam int CNT_W_DEF      = 2;

   // True when predicate idx has a counter; p3 and anything past NUM_PREDS is never tracked
   function automatic logic pred_tracked(input logic [PRED_IDX_W-1:0] idx, input int num_preds);
      return (int'(idx) < num_preds) && (int'(idx) != PRED_CONST_IDX);
   endfunction

endpackage

// File: rtl/scoreboard_mc_entry.sv
// One pending-write counter: adds claims, subtracts releases, clamps into [0, max]
// and flags overflow/underflow for the cycle it happens.
module sb_entry #(
   parameter int CNT_W = 2,
   parameter int POP_W = 2,
   parameter int SUM_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [POP_W-1:0] claim,
   input  logic [POP_W-1:0] rel,
   output logic             busy,
   output logic             full,
   output logic             err
);

   localparam logic signed [SUM_W-1:0] MAX = SUM_W'((1 << CNT_W) - 1);

   logic [CNT_W-1:0]        cnt;
   logic signed [SUM_W-1:0] sum;
   logic                    ovf, unf;

   always_comb begin
      sum = $signed(SUM_W'(cnt)) + $signed(SUM_W'(claim)) - $signed(SUM_W'(rel));
      ovf = (sum > MAX);
      unf = (sum < 0);
   end

   always_ff @(posedge clk) begin
      if (rst)        cnt <= '0;
      else if (flush) cnt <= '0;
      else if (ovf)   cnt <= '1;
      else if (unf)   cnt <= '0;
      else            cnt <= sum[CNT_W-1:0];
   end

   // Flush discards the cycle's traffic, so it cannot produce an error either
   assign err  = !flush && (ovf || unf);
   assign busy = (cnt != '0);
   assign full = &cnt;

endmodule

// File: rtl/scoreboard_mc.sv
// Multi-issue GPR/predicate scoreboard: per-entry claim/release decode feeding one
// counter per entry, plus the sticky error flag.
module scoreboard_mc
   import scoreboard_mc_pkg::*;
#(
   parameter int NUM_REGS    = 32,
   parameter int NUM_PREDS   = 3,
   parameter int ISSUE_LANES = 2,
   parameter int WB_PORTS    = 2,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int RN_W        = $clog2(NUM_REGS)
) (
   input  logic                          clkrst_core_clk,
   input  logic                          clkrst_core_rst,
   input  logic [ISSUE_LANES-1:0]        iss_valid,
   input  logic [ISSUE_LANES*RN_W-1:0]   iss_rd_num,
   input  logic [ISSUE_LANES-1:0]        iss_rd_we,
   input  logic [ISSUE_LANES-1:0]        iss_pred_we,
   input  logic [WB_PORTS-1:0]           wb_valid,
   input  logic [WB_PORTS*RN_W-1:0]      wb_num,
   input  logic [WB_PORTS-1:0]           wb_is_pred,
   input  logic                          flush,
   output logic [NUM_REGS-1:0]           sb2d_reg_scoreboard,
   output logic [NUM_PREDS-1:0]          sb2d_pred_scoreboard,
   output logic [NUM_REGS+NUM_PREDS-1:0] sb_full,
   output logic                          sb_err
);

   localparam int NUM_ENT = NUM_REGS + NUM_PREDS;
   localparam int MAX_POP = (ISSUE_LANES > WB_PORTS) ? ISSUE_LANES : WB_PORTS;
   localparam int POP_W   = $clog2(MAX_POP + 1);
   localparam int SUM_W   = CNT_W + $clog2(ISSUE_LANES + WB_PORTS) + 1;

   logic [NUM_ENT-1:0][POP_W-1:0] claim, rel;
   logic [NUM_ENT-1:0]            busy, full, err;

   // Entries 0..NUM_REGS-1 are GPRs, the rest are predicates in index order
   always_comb begin
      claim = '0;
      rel   = '0;
      for (int e = 0; e < NUM_REGS; e++) begin
         for (int i = 0; i < ISSUE_LANES; i++)
            if (iss_valid[i] && iss_rd_we[i] && iss_rd_num[i*RN_W +: RN_W] == RN_W'(e))
               claim[e] = claim[e] + POP_W'(1);
         for (int j = 0; j < WB_PORTS; j++)
            if (wb_valid[j] && !wb_is_pred[j] && wb_num[j*RN_W +: RN_W] == RN_W'(e))
               rel[e] = rel[e] + POP_W'(1);
      end
      for (int p = 0; p < NUM_PREDS; p++) begin
         if (pred_tracked(PRED_IDX_W'(p), NUM_PREDS)) begin
            for (int i = 0; i < ISSUE_LANES; i++)
               if (iss_valid[i] && iss_pred_we[i] &&
                   iss_rd_num[i*RN_W +: PRED_IDX_W] == PRED_IDX_W'(p))
                  claim[NUM_REGS+p] = claim[NUM_REGS+p] + POP_W'(1);
            for (int j = 0; j < WB_PORTS; j++)
               if (wb_valid[j] && wb_is_pred[j] &&
                   wb_num[j*RN_W +: PRED_IDX_W] == PRED_IDX_W'(p))
                  rel[NUM_REGS+p] = rel[NUM_REGS+p] + POP_W'(1);
         end
      end
   end

   for (genvar e = 0; e < NUM_ENT; e++) begin : g_ent
      sb_entry #(.CNT_W(CNT_W), .POP_W(POP_W), .SUM_W(SUM_W)) u_ent (
         .clk   (clkrst_core_clk),
         .rst   (clkrst_core_rst),
         .flush (flush),
         .claim (claim[e]),
         .rel   (rel[e]),
         .busy  (busy[e]),
         .full  (full[e]),
         .err   (err[e])
      );
   end

   always_ff @(posedge clkrst_core_clk) begin
      if (clkrst_core_rst) sb_err <= 1'b0;
      else if (|err)       sb_err <= 1'b1;
   end

   assign sb2d_reg_scoreboard  = busy[NUM_REGS-1:0];
   assign sb2d_pred_scoreboard = busy[NUM_ENT-1:NUM_REGS];
   assign sb_full              = full;

endmodule

// File: tb/tb_scoreboard_mc.sv
// Bench for scoreboard_mc: directed scenarios then random traffic, checked by a queue-based
// scoreboard against an integer-count reference model.
module tb_scoreboard_mc;

   localparam int NR = 32, NP = 3, IL = 2, WP = 2, CW = 2, RW = 5;
   localparam int NE = NR + NP;
   localparam int MAXC = (1 << CW) - 1;

   logic            clk = 0;
   logic            rst;
   logic [IL-1:0]   iss_valid, iss_rd_we, iss_pred_we;
   logic [IL*RW-1:0] iss_rd_num;
   logic [WP-1:0]   wb_valid, wb_is_pred;
   logic [WP*RW-1:0] wb_num;
   logic            flush;
   logic [NR-1:0]   reg_sb;
   logic [NP-1:0]   pred_sb;
   logic [NE-1:0]   full;
   logic            err;

   scoreboard_mc #(.NUM_REGS(NR), .NUM_PREDS(NP), .ISSUE_LANES(IL), .WB_PORTS(WP), .CNT_W(CW)) dut (
      .clkrst_core_clk(clk), .clkrst_core_rst(rst),
      .iss_valid(iss_valid), .iss_rd_num(iss_rd_num), .iss_rd_we(iss_rd_we), .iss_pred_we(iss_pred_we),
      .wb_valid(wb_valid), .wb_num(wb_num), .wb_is_pred(wb_is_pred), .flush(flush),
      .sb2d_reg_scoreboard(reg_sb), .sb2d_pred_scoreboard(pred_sb), .sb_full(full), .sb_err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NR-1:0] rb;
      logic [NP-1:0] pb;
      logic [NE-1:0] fl;
      logic          er;
   } exp_t;

   exp_t q[$];
   int   total = 0, bad = 0;
   int   cnt[NE];
   bit   err_m = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: compares the DUT state after each edge with the model's prediction for it
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("reg_busy",  64'(reg_sb),  64'(e.rb));
            chk("pred_busy", 64'(pred_sb), 64'(e.pb));
            chk("full",      64'(full),    64'(e.fl));
            chk("err",       64'(err),     64'(e.er));
         end
      end
   end

   // Reference: add up signed deltas per destination, then clamp the resulting count
   task automatic model_step();
      int   d[NE];
      exp_t e;
      foreach (d[k]) d[k] = 0;
      if (rst) begin
         foreach (cnt[k]) cnt[k] = 0;
         err_m = 0;
      end else if (flush) begin
         foreach (cnt[k]) cnt[k] = 0;
      end else begin
         for (int i = 0; i < IL; i++) begin
            int rn;
            rn = int'(iss_rd_num[i*RW +: RW]);
            if (iss_valid[i] && iss_rd_we[i]) d[rn]++;
            if (iss_valid[i] && iss_pred_we[i] && (rn % 4) < NP) d[NR + rn % 4]++;
         end
         for (int j = 0; j < WP; j++) begin
            int wn;
            wn = int'(wb_num[j*RW +: RW]);
            if (wb_valid[j]) begin
               if (!wb_is_pred[j]) d[wn]--;
               else if ((wn % 4) < NP) d[NR + wn % 4]--;
            end
         end
         for (int k = 0; k < NE; k++) begin
            int s;
            s = cnt[k] + d[k];
            if (s > MAXC) begin cnt[k] = MAXC; err_m = 1; end
            else if (s < 0) begin cnt[k] = 0; err_m = 1; end
            else cnt[k] = s;
         end
      end
      for (int k = 0; k < NE; k++) begin
         if (k < NR) e.rb[k] = (cnt[k] != 0);
         else        e.pb[k-NR] = (cnt[k] != 0);
         e.fl[k] = (cnt[k] == MAXC);
      end
      e.er = err_m;
      q.push_back(e);
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      rst = 0; flush = 0;
      iss_valid = '0; iss_rd_we = '0; iss_pred_we = '0; iss_rd_num = '0;
      wb_valid = '0; wb_is_pred = '0; wb_num = '0;
   endtask

   task automatic claim2(input int r0, input int r1, input logic [1:0] v);
      iss_valid = v; iss_rd_we = v; iss_pred_we = '0;
      iss_rd_num = {RW'(r1), RW'(r0)};
   endtask

   task automatic wb1(input int n, input logic is_p);
      wb_valid = 2'b01; wb_is_pred = {1'b0, is_p}; wb_num = {RW'(0), RW'(n)};
   endtask

   initial begin
      idle();
      rst = 1;
      step(); step();
      idle();

      // reset mid-traffic: r5 to 2, then reset with a dual claim on r5
      claim2(5, 5, 2'b11); step();
      claim2(5, 5, 2'b11); rst = 1; step();
      idle(); step();

      // dual issue to r7, then two writebacks
      claim2(7, 7, 2'b11); step();
      idle(); step();
      wb1(7, 0); step();
      idle(); step();
      wb1(7, 0); step();
      idle(); step();

      // simultaneous claim/release on r3 holding one claim
      claim2(3, 0, 2'b01); step();
      claim2(3, 0, 2'b01); wb1(3, 0); step();
      idle(); wb1(3, 0); step();
      idle(); step();

      // predicates: p2 claim, p3 ignored, p2 release
      iss_valid = 2'b01; iss_pred_we = 2'b01; iss_rd_num = {RW'(0), RW'(2)}; step();
      iss_rd_num = {RW'(0), RW'(3)}; step();
      idle(); wb1(2, 1); step();
      idle(); wb1(3, 1); step();
      idle(); step();

      // overflow on r9, then flush with a concurrent r1 claim
      for (int k = 0; k < 4; k++) begin claim2(9, 0, 2'b01); step(); end
      idle(); step();
      flush = 1; claim2(1, 0, 2'b01); step();
      idle(); step();

      // underflow on r12 after a reset clears the sticky error
      rst = 1; step();
      idle(); wb1(12, 0); step();
      idle(); step();

      // random traffic over a small destination set to force collisions
      for (int c = 0; c < 600; c++) begin
         idle();
         for (int i = 0; i < IL; i++) begin
            iss_valid[i]   = ($urandom_range(0, 99) < 60);
            iss_rd_we[i]   = ($urandom_range(0, 99) < 70);
            iss_pred_we[i] = ($urandom_range(0, 99) < 25);
            iss_rd_num[i*RW +: RW] = RW'($urandom_range(0, 5));
         end
         for (int j = 0; j < WP; j++) begin
            wb_valid[j]   = ($urandom_range(0, 99) < 45);
            wb_is_pred[j] = ($urandom_range(0, 99) < 25);
            wb_num[j*RW +: RW] = RW'($urandom_range(0, 5));
         end
         flush = ($urandom_range(0, 49) == 0);
         rst   = ($urandom_range(0, 39) == 0);
         step();
      end
      idle(); step();

      @(posedge clk); #3;
      chk("queue_drained", 64'(q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
